// File: rtl/bcd_print_pkg.sv
// Shared types and helpers for the BCD print scheduler: FSM states, ASCII constants,
// and digit indexing over the packed {tenK,thou,hund,tens,unit} BCD word.
package bcd_print_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GRANT,
    ST_START,
    ST_WAIT,
    ST_CAPTURE,
    ST_SEND,
    ST_TERM
  } state_e;

  localparam logic [7:0]  ASCII_ZERO = 8'h30;
  localparam logic [7:0]  ASCII_ERR  = 8'h3F;
  localparam int unsigned NUM_DIGITS = 5;
  localparam int unsigned DIG_IDX_W  = 3;

  typedef logic [DIG_IDX_W-1:0] dig_idx_t;

  // Index 0 is the ten-thousands digit; index 4 is the units digit.
  localparam dig_idx_t DIG_UNIT = 3'd4;

  function automatic logic [3:0] digit_at(input logic [19:0] digits, input dig_idx_t idx);
    logic [3:0] d;
    case (idx)
      3'd0:    d = digits[19:16];
      3'd1:    d = digits[15:12];
      3'd2:    d = digits[11:8];
      3'd3:    d = digits[7:4];
      default: d = digits[3:0];
    endcase
    return d;
  endfunction

  function automatic dig_idx_t first_nonzero(input logic [19:0] digits);
    dig_idx_t idx;
    logic     found;
    idx   = DIG_UNIT;
    found = 1'b0;
    for (int unsigned k = 0; k < NUM_DIGITS - 1; k++) begin
      if (!found && digit_at(digits, dig_idx_t'(k)) != 4'h0) begin
        idx   = dig_idx_t'(k);
        found = 1'b1;
      end
    end
    return idx;
  endfunction

  function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
    return (d > 4'd9) ? ASCII_ERR : (ASCII_ZERO | {4'h0, d});
  endfunction

endpackage

// File: rtl/bcd_print_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requesting index at or after ptr,
// wrapping around. The pointer register is owned by the parent.
module rr_arbiter #(
  parameter int unsigned N = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  localparam logic [N-1:0] ONE = N'(1);

  int unsigned  cand;
  logic [N-1:0] cand_oh;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    cand_oh   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      cand    = (32'(ptr) + k) % N;
      cand_oh = ONE << cand;
      if (!any && |(req & cand_oh)) begin
        any       = 1'b1;
        grant     = cand_oh;
        grant_idx = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/bcd_print_scheduler.sv
// Shares one bin2BCD converter among NUM_REQ requesters (round-robin) and streams the
// result as ASCII with leading zeros suppressed, followed by TERM_CHAR, to a byte sink.
module bcd_print_scheduler
  import bcd_print_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter logic [7:0]  TERM_CHAR    = 8'h0D,
  parameter int unsigned CONV_TIMEOUT = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic                          conv_en,
  output logic [DATA_WIDTH-1:0]         conv_data,
  input  logic                          conv_done,
  input  logic [19:0]                   conv_digits,
  output logic [7:0]                    tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  output logic                          busy,
  output logic                          err_timeout
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CW = $clog2(CONV_TIMEOUT + 1);

  typedef logic [IW-1:0] idx_t;
  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t CNT_LAST = cnt_t'(CONV_TIMEOUT - 1);
  localparam idx_t IDX_LAST = idx_t'(NUM_REQ - 1);

  state_e                state_q, state_d;
  idx_t                  ptr_q, ptr_d;
  idx_t                  gnt_idx_q, gnt_idx_d;
  logic [NUM_REQ-1:0]    gnt_oh_q, gnt_oh_d;
  logic [DATA_WIDTH-1:0] conv_data_q, conv_data_d;
  cnt_t                  cnt_q, cnt_d;
  logic [19:0]           digits_q, digits_d;
  dig_idx_t              dig_idx_q, dig_idx_d;

  logic [NUM_REQ-1:0]    arb_grant;
  idx_t                  arb_idx;
  logic                  arb_any;
  logic [DATA_WIDTH-1:0] sel_data;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req       (req_valid),
    .ptr       (ptr_q),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any       (arb_any)
  );

  always_comb begin
    sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh_q[i]) sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      gnt_idx_q   <= '0;
      gnt_oh_q    <= '0;
      conv_data_q <= '0;
      cnt_q       <= '0;
      digits_q    <= '0;
      dig_idx_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_oh_q    <= gnt_oh_d;
      conv_data_q <= conv_data_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      dig_idx_q   <= dig_idx_d;
    end
  end

  // The grant is chosen and frozen in IDLE so later req_valid changes cannot alter it.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_oh_d    = gnt_oh_q;
    conv_data_d = conv_data_q;
    cnt_d       = cnt_q;
    digits_d    = digits_q;
    dig_idx_d   = dig_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (arb_any) begin
          gnt_idx_d = arb_idx;
          gnt_oh_d  = arb_grant;
          state_d   = ST_GRANT;
        end
      end
      ST_GRANT: begin
        conv_data_d = sel_data;
        ptr_d       = (gnt_idx_q == IDX_LAST) ? '0 : gnt_idx_q + idx_t'(1);
        state_d     = ST_START;
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (conv_done) begin
          state_d = ST_CAPTURE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + cnt_t'(1);
        end
      end
      ST_CAPTURE: begin
        digits_d  = conv_digits;
        dig_idx_d = first_nonzero(conv_digits);
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          if (dig_idx_q == DIG_UNIT) state_d = ST_TERM;
          else dig_idx_d = dig_idx_q + dig_idx_t'(1);
        end
      end
      ST_TERM: begin
        if (tx_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ack     = (state_q == ST_GRANT) ? gnt_oh_q : '0;
    conv_en     = (state_q == ST_START);
    conv_data   = conv_data_q;
    busy        = (state_q != ST_IDLE);
    err_timeout = (state_q == ST_WAIT) && !conv_done && (cnt_q == CNT_LAST);
    tx_valid    = (state_q == ST_SEND) || (state_q == ST_TERM);
    tx_data     = '0;
    if (state_q == ST_SEND) tx_data = digit_to_ascii(digit_at(digits_q, dig_idx_q));
    else if (state_q == ST_TERM) tx_data = TERM_CHAR;
  end

endmodule

// File: tb/tb_bcd_print_scheduler.sv
// Scoreboard bench for bcd_print_scheduler with a behavioural converter and decimal-print model.
module tb_bcd_print_scheduler;

  localparam int         NR   = 4;
  localparam int         DW   = 16;
  localparam int         TO   = 64;
  localparam logic [7:0] TERM = 8'h0D;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NR-1:0]    req_valid;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ack;
  logic             conv_en;
  logic [DW-1:0]    conv_data;
  logic             conv_done;
  logic [19:0]      conv_digits;
  logic [7:0]       tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;
  logic             err_timeout;

  bcd_print_scheduler #(
    .NUM_REQ      (NR),
    .DATA_WIDTH   (DW),
    .TERM_CHAR    (TERM),
    .CONV_TIMEOUT (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_ack     (req_ack),
    .conv_en     (conv_en),
    .conv_data   (conv_data),
    .conv_done   (conv_done),
    .conv_digits (conv_digits),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  logic [7:0]  exp_bytes[$];
  int          exp_grants[$];
  int          m_ptr = 0;
  int          cyc = 0;
  int          en_cyc = 0;
  bit          timeout_expected = 0;
  bit          conv_hang = 0;
  bit          force_digits = 0;
  logic [19:0] forced_val = '0;
  int          ready_mode = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  function automatic logic [19:0] bin_to_digits(input int v);
    return {4'(v / 10000 % 10), 4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  task automatic push_value(input int v);
    string s;
    s = $sformatf("%0d", v);
    for (int i = 0; i < s.len(); i++) exp_bytes.push_back(8'(s[i]));
    exp_bytes.push_back(TERM);
  endtask

  // Round-robin reference: each pending requester is served once, nearest at/after the pointer first.
  task automatic plan(input logic [NR-1:0] mask, input bit with_bytes);
    logic [NR-1:0] pending;
    int            c;
    pending = mask;
    while (pending != '0) begin
      for (int k = 0; k < NR; k++) begin
        c = (m_ptr + k) % NR;
        if (pending[c]) begin
          exp_grants.push_back(c);
          if (with_bytes) push_value(int'(req_data[c*DW +: DW]));
          pending[c] = 1'b0;
          m_ptr = (c + 1) % NR;
          break;
        end
      end
    end
  endtask

  task automatic serve(input logic [NR-1:0] mask, input int n_acks, input bit drop);
    int got;
    int t;
    got = 0;
    t = 0;
    req_valid = mask;
    while (got < n_acks && t < 2000) begin
      @(negedge clk);
      t++;
      if (req_ack != '0) begin
        got++;
        if (drop) req_valid &= ~req_ack;
      end
    end
    if (got < n_acks) fail_now("ack_wait");
    req_valid = '0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((busy || exp_bytes.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) fail_now("idle_wait");
    check("grants_drained", 32'(exp_grants.size()), 0);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_ack"}, 32'(req_ack), 0);
    check({tag, "_conv_en"}, 32'(conv_en), 0);
    check({tag, "_conv_data"}, 32'(conv_data), 0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 0);
    check({tag, "_tx_data"}, 32'(tx_data), 0);
    check({tag, "_busy"}, 32'(busy), 0);
    check({tag, "_err_timeout"}, 32'(err_timeout), 0);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Converter: random latency, digits valid only in the cycle after conv_done.
  initial begin
    int            lat;
    logic [DW-1:0] v;
    conv_done   = 1'b0;
    conv_digits = '0;
    forever begin
      @(negedge clk);
      if (conv_en === 1'b1 && rst_n === 1'b1) begin
        en_cyc = cyc;
        v = conv_data;
        if (!conv_hang) begin
          lat = $urandom_range(1, 8);
          repeat (lat) @(negedge clk);
          conv_done   = 1'b1;
          conv_digits = 20'($urandom);
          @(negedge clk);
          conv_done   = 1'b0;
          conv_digits = force_digits ? forced_val : bin_to_digits(int'(v));
          @(negedge clk);
          conv_digits = 20'($urandom);
        end
      end
    end
  end

  initial begin
    bit         stall_prev;
    logic [7:0] data_prev;
    int         g;
    stall_prev = 0;
    data_prev  = '0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        stall_prev = 0;
        continue;
      end
      if (stall_prev) begin
        check("tx_hold_valid", 32'(tx_valid), 1);
        check("tx_hold_data", 32'(tx_data), 32'(data_prev));
      end
      if (tx_valid && tx_ready) begin
        if (exp_bytes.size() == 0) fail_now("unexpected_byte");
        else check("tx_byte", 32'(tx_data), 32'(exp_bytes.pop_front()));
      end
      stall_prev = tx_valid && !tx_ready;
      data_prev  = tx_data;
      if (req_ack != '0) begin
        check("ack_onehot", 32'($onehot(req_ack)), 1);
        if (exp_grants.size() == 0) fail_now("unexpected_ack");
        else begin
          g = exp_grants.pop_front();
          check("grant_idx", 32'(req_ack), 32'(1) << g);
        end
      end
      if (err_timeout) begin
        check("timeout_expected", 32'(timeout_expected), 1);
        check("timeout_delay", 32'(cyc - en_cyc), TO);
        timeout_expected = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NR-1:0] mask;
    int            c;
    int            t;
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // All requesters held: strict rotation starting at pointer 0, one ack per grant.
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'($urandom);
    for (int k = 0; k < 8; k++) begin
      c = (m_ptr + k) % NR;
      exp_grants.push_back(c);
      push_value(int'(req_data[c*DW +: DW]));
    end
    serve('1, 8, 0);
    wait_idle();

    req_data[0*DW +: DW] = 16'd305;
    plan(4'b0001, 1);
    serve(4'b0001, 1, 1);
    wait_idle();

    req_data[2*DW +: DW] = 16'd0;
    plan(4'b0100, 1);
    serve(4'b0100, 1, 1);
    wait_idle();
    req_data[1*DW +: DW] = 16'd65535;
    plan(4'b0010, 1);
    serve(4'b0010, 1, 1);
    wait_idle();

    // Random backpressure plus random request subsets.
    ready_mode = 1;
    req_data[0*DW +: DW] = 16'd305;
    plan(4'b0001, 1);
    serve(4'b0001, 1, 1);
    wait_idle();
    for (int r = 0; r < 6; r++) begin
      mask = NR'($urandom_range(1, (1 << NR) - 1));
      for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'($urandom);
      plan(mask, 1);
      serve(mask, $countones(mask), 1);
      wait_idle();
    end
    ready_mode = 0;

    // Converter never answers.
    conv_hang = 1;
    req_data[3*DW +: DW] = 16'd777;
    plan(4'b1000, 0);
    timeout_expected = 1;
    serve(4'b1000, 1, 1);
    wait_idle();
    check("timeout_seen", 32'(timeout_expected), 0);
    conv_hang = 0;
    req_data[2*DW +: DW] = 16'd4096;
    plan(4'b0100, 1);
    serve(4'b0100, 1, 1);
    wait_idle();

    // Reset while a byte is stalled in SEND.
    ready_mode = 2;
    req_data[1*DW +: DW] = 16'd12345;
    plan(4'b0010, 1);
    serve(4'b0010, 1, 1);
    t = 0;
    while (!tx_valid && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!tx_valid) fail_now("send_reached");
    @(negedge clk);
    rst_n = 1'b0;
    exp_bytes.delete();
    m_ptr = 0;
    #1;
    check_outputs_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ready_mode = 0;
    @(negedge clk);

    force_digits = 1;
    forced_val   = {4'h0, 4'hA, 4'h1, 4'h2, 4'h3};
    req_data[3*DW +: DW] = 16'd123;
    plan(4'b1000, 0);
    exp_bytes.push_back(8'h3F);
    exp_bytes.push_back(8'h31);
    exp_bytes.push_back(8'h32);
    exp_bytes.push_back(8'h33);
    exp_bytes.push_back(TERM);
    serve(4'b1000, 1, 1);
    wait_idle();
    force_digits = 0;

    req_data[0*DW +: DW] = 16'd9;
    req_data[2*DW +: DW] = 16'd50020;
    plan(4'b0101, 1);
    serve(4'b0101, 2, 1);
    wait_idle();

    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
